// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, write FSM encoding and sizing helpers.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, SRESP} wr_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Index width for a lane/beat selector; never narrower than one bit.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axil_wr_lane_mux.sv
// Combinational lane steering for a width adapter: replicate/place on upsize,
// slice on downsize, pass-through when widths match.
module axil_wr_lane_mux
    import axil_pkg::*;
#(
    parameter int S_DATA_WIDTH = 32,
    parameter int M_DATA_WIDTH = 32,
    parameter int S_STRB_WIDTH = S_DATA_WIDTH / 8,
    parameter int M_STRB_WIDTH = M_DATA_WIDTH / 8,
    parameter int RATIO        = (M_DATA_WIDTH > S_DATA_WIDTH) ? M_DATA_WIDTH / S_DATA_WIDTH
                                                               : S_DATA_WIDTH / M_DATA_WIDTH,
    parameter int IDX_W        = idx_width(RATIO)
) (
    input  logic [S_DATA_WIDTH-1:0] s_data,
    input  logic [S_STRB_WIDTH-1:0] s_strb,
    input  logic [IDX_W-1:0]        lane,
    input  logic [IDX_W-1:0]        beat,
    output logic [M_DATA_WIDTH-1:0] m_data,
    output logic [M_STRB_WIDTH-1:0] m_strb
);

    generate
        if (M_DATA_WIDTH > S_DATA_WIDTH) begin : g_up
            for (genvar k = 0; k < RATIO; k++) begin : g_lane
                assign m_data[k*S_DATA_WIDTH +: S_DATA_WIDTH] = s_data;
                assign m_strb[k*S_STRB_WIDTH +: S_STRB_WIDTH] =
                    (lane == IDX_W'(k)) ? s_strb : '0;
            end
        end else if (M_DATA_WIDTH < S_DATA_WIDTH) begin : g_dn
            assign m_data = s_data[beat*M_DATA_WIDTH +: M_DATA_WIDTH];
            assign m_strb = s_strb[beat*M_STRB_WIDTH +: M_STRB_WIDTH];
        end else begin : g_eq
            assign m_data = s_data;
            assign m_strb = s_strb;
        end
    endgenerate

endmodule

// File: rtl/axil_wr_width_adapter.sv
// AXI4-Lite write-channel width adapter: captures AW/W independently, issues one
// (equal/upsize) or RATIO (downsize) master beats and merges the responses.
module axil_wr_width_adapter
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int S_DATA_WIDTH = 32,
    parameter int M_DATA_WIDTH = 32,
    parameter int S_STRB_WIDTH = S_DATA_WIDTH / 8,
    parameter int M_STRB_WIDTH = M_DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [S_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [S_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [M_DATA_WIDTH-1:0] m_axil_wdata,
    output logic [M_STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready
);

    localparam int RATIO = (M_DATA_WIDTH > S_DATA_WIDTH) ? M_DATA_WIDTH / S_DATA_WIDTH
                                                         : S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int BEATS = (M_DATA_WIDTH < S_DATA_WIDTH) ? RATIO : 1;
    localparam int IDX_W = idx_width(RATIO);
    localparam int S_OFF = clog2(S_STRB_WIDTH);
    localparam int M_OFF = clog2(M_STRB_WIDTH);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    wr_state_t               state;
    logic                    aw_captured, w_captured;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [2:0]              prot_reg;
    logic [S_DATA_WIDTH-1:0] data_reg;
    logic [S_STRB_WIDTH-1:0] strb_reg;
    logic [IDX_W-1:0]        beat_cnt;
    logic [1:0]              resp_acc;

    logic                    aw_hs, w_hs, aw_have, w_have;
    logic [ADDR_WIDTH-1:0]   eff_addr, mux_addr;
    logic [2:0]              eff_prot;
    logic [S_DATA_WIDTH-1:0] eff_data;
    logic [S_STRB_WIDTH-1:0] eff_strb;
    logic [IDX_W-1:0]        nxt_beat, lane;
    logic [M_DATA_WIDTH-1:0] mux_data;
    logic [M_STRB_WIDTH-1:0] mux_strb;
    logic [1:0]              resp_merged;

    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid && s_axil_wready;
    assign aw_have = aw_captured || aw_hs;
    assign w_have  = w_captured || w_hs;

    // Beat 0 is built straight from the slave bus when its handshake is the later one,
    // so the master valids can rise on the very next cycle.
    assign eff_addr = aw_hs ? s_axil_awaddr : addr_reg;
    assign eff_prot = aw_hs ? s_axil_awprot : prot_reg;
    assign eff_data = w_hs  ? s_axil_wdata  : data_reg;
    assign eff_strb = w_hs  ? s_axil_wstrb  : strb_reg;
    assign nxt_beat = (state == RESP) ? beat_cnt + 1'b1 : '0;

    assign resp_merged = (resp_acc != RESP_OKAY) ? resp_acc : m_axil_bresp;

    generate
        if (M_DATA_WIDTH > S_DATA_WIDTH) begin : g_up
            assign lane     = eff_addr[M_OFF-1:S_OFF];
            assign mux_addr = eff_addr;
        end else if (M_DATA_WIDTH < S_DATA_WIDTH) begin : g_dn
            assign lane     = '0;
            assign mux_addr = (eff_addr & ~ADDR_WIDTH'(S_STRB_WIDTH - 1))
                            + (ADDR_WIDTH'(nxt_beat) << M_OFF);
        end else begin : g_eq
            assign lane     = '0;
            assign mux_addr = eff_addr;
        end
    endgenerate

    axil_wr_lane_mux #(
        .S_DATA_WIDTH (S_DATA_WIDTH),
        .M_DATA_WIDTH (M_DATA_WIDTH),
        .S_STRB_WIDTH (S_STRB_WIDTH),
        .M_STRB_WIDTH (M_STRB_WIDTH),
        .RATIO        (RATIO),
        .IDX_W        (IDX_W)
    ) u_lane_mux (
        .s_data (eff_data),
        .s_strb (eff_strb),
        .lane   (lane),
        .beat   (nxt_beat),
        .m_data (mux_data),
        .m_strb (mux_strb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            aw_captured    <= 1'b0;
            w_captured     <= 1'b0;
            beat_cnt       <= '0;
            resp_acc       <= RESP_OKAY;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        aw_captured <= 1'b1;
                        addr_reg    <= s_axil_awaddr;
                        prot_reg    <= s_axil_awprot;
                    end
                    if (w_hs) begin
                        w_captured <= 1'b1;
                        data_reg   <= s_axil_wdata;
                        strb_reg   <= s_axil_wstrb;
                    end
                    s_axil_awready <= !aw_have;
                    s_axil_wready  <= !w_have;
                    if (aw_have && w_have) begin
                        state          <= ISSUE;
                        beat_cnt       <= '0;
                        resp_acc       <= RESP_OKAY;
                        m_axil_awvalid <= 1'b1;
                        m_axil_wvalid  <= 1'b1;
                        m_axil_awaddr  <= mux_addr;
                        m_axil_awprot  <= eff_prot;
                        m_axil_wdata   <= mux_data;
                        m_axil_wstrb   <= mux_strb;
                    end
                end
                ISSUE: begin
                    if (m_axil_awvalid && m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wvalid && m_axil_wready)   m_axil_wvalid  <= 1'b0;
                    if ((!m_axil_awvalid || m_axil_awready) && (!m_axil_wvalid || m_axil_wready)) begin
                        state         <= RESP;
                        m_axil_bready <= 1'b1;
                    end
                end
                RESP: begin
                    if (m_axil_bvalid && m_axil_bready) begin
                        resp_acc      <= resp_merged;
                        m_axil_bready <= 1'b0;
                        if (beat_cnt == LAST_BEAT) begin
                            state         <= SRESP;
                            s_axil_bvalid <= 1'b1;
                            s_axil_bresp  <= resp_merged;
                        end else begin
                            state          <= ISSUE;
                            beat_cnt       <= nxt_beat;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            m_axil_awaddr  <= mux_addr;
                            m_axil_awprot  <= eff_prot;
                            m_axil_wdata   <= mux_data;
                            m_axil_wstrb   <= mux_strb;
                        end
                    end
                end
                SRESP: begin
                    if (s_axil_bready) begin
                        state          <= IDLE;
                        s_axil_bvalid  <= 1'b0;
                        aw_captured    <= 1'b0;
                        w_captured     <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
